// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared register-file widths and writeback requester indices
package rf_arb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;
    localparam reg_addr_t ZERO_REG = 5'd0;
    localparam int REQ_WB = 0;
    localparam int REQ_MD = 1;
    localparam int REQ_CP0 = 2;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: requester bus plus register-file write port of the writeback arbiter
interface rf_wb_arbiter_if #(parameter int NREQ = 3) ();
    import rf_arb_pkg::*;
    logic [NREQ-1:0] req_valid;
    logic [REG_ADDR_W*NREQ-1:0] req_addr;
    logic [REG_DATA_W*NREQ-1:0] req_data;
    logic [NREQ-1:0] req_ready;
    logic rf_we;
    reg_addr_t rf_addr;
    reg_data_t rf_wdata;
    logic [NREQ-1:0] starve;
    logic busy;
    modport master (output req_valid, req_addr, req_data,
                    input req_ready, rf_we, rf_addr, rf_wdata, starve, busy);
    modport slave (input req_valid, req_addr, req_data,
                   output req_ready, rf_we, rf_addr, rf_wdata, starve, busy);
endinterface

// File: rtl/rf_wb_arbiter_rr_pick.sv
// rr_pick: rotating priority encoder, first valid at or above ptr (mod N) wins
module rr_pick #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] valid_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);
    int j;
    // Scan from the farthest offset down so the nearest valid one overwrites last
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k >= N ? int'(ptr_i) + k - N : int'(ptr_i) + k;
            if (valid_i[j]) begin
                gnt_o = '0;
                gnt_o[j] = 1'b1;
                idx_o = W'(j);
            end
        end
    end
    assign any_o = |valid_i;
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the RF write port with registered output and starvation flags.
// Define RF_ARB_FIXED_PRI_EN for fixed lowest-index-wins priority (no rotation pointer).
module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int MAX_WAIT = 7,
    parameter int CNT_W = 3
) (
    input logic clk,
    input logic reset,
    rf_wb_arbiter_if.slave bus
);
    localparam int PW = idx_w(NREQ);
    logic [PW-1:0] ptr_q, idx;
    logic [NREQ-1:0] gnt, ready, starve_q, starve_d;
    logic any, take, we_q, we_d, rf_we;
    logic [NREQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
    reg_addr_t addr_q, addr_d, sel_addr;
    reg_data_t data_q, data_d, sel_data;

    rr_pick #(.N(NREQ), .W(PW)) u_pick (
        .valid_i(bus.req_valid),
        .ptr_i(ptr_q),
        .gnt_o(gnt),
        .idx_o(idx),
        .any_o(any)
    );

`ifdef RF_ARB_FIXED_PRI_EN
    assign ptr_q = '0;
`else
    logic [PW-1:0] ptr_d;
    assign ptr_d = !take ? ptr_q : idx == PW'(NREQ - 1) ? '0 : idx + 1'b1;
    always_ff @(posedge clk) ptr_q <= reset ? '0 : ptr_d;
`endif

    assign take = any & ~reset;
    assign ready = gnt & {NREQ{~reset}};
    assign sel_addr = bus.req_addr[REG_ADDR_W*idx +: REG_ADDR_W];
    assign sel_data = bus.req_data[REG_DATA_W*idx +: REG_DATA_W];
    // Writes to $0 are consumed but never reach the register file
    assign we_d = take && sel_addr != ZERO_REG;
    assign addr_d = take ? sel_addr : addr_q;
    assign data_d = take ? sel_data : data_q;

    always_comb begin
        cnt_d = '0;
        starve_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = !bus.req_valid[i] || ready[i] ? '0 :
                       cnt_q[i] == CNT_W'(MAX_WAIT) ? cnt_q[i] : cnt_q[i] + 1'b1;
            starve_d[i] = cnt_d[i] == CNT_W'(MAX_WAIT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            cnt_q <= '0;
            starve_q <= '0;
        end else begin
            we_q <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            cnt_q <= cnt_d;
            starve_q <= starve_d;
        end
    end

    // Gating with reset drops a write that was already registered when reset arrives
    assign rf_we = we_q & ~reset;
    assign bus.req_ready = ready;
    assign bus.rf_we = rf_we;
    assign bus.rf_addr = addr_q;
    assign bus.rf_wdata = data_q;
    assign bus.starve = starve_q;
    assign bus.busy = |bus.req_valid | rf_we;
endmodule
